mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 8:1 data-select path. It lets eight requesters (ports a..h, indices 0..7) share one output channel. Each cycle it picks a winner and drives the select code. It captures the winner's data into a registered output stage with a valid/ready handshake, and it supports bounded bursts so that one requester can stream back-to-back beats without starving the others.

---
 rtl/mux8_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter feeding the 8:1 data-select path. Each cycle the
//   output stage can load, one requester is granted (ack_o), and its data is
//   captured into a registered output with a valid/ready handshake. A grantee
//   may keep the channel for up to BURST_LEN consecutive beats.
//
// Ports
//   clk_i    clock, all state on rising edge
//   rst_i    synchronous active-high reset
//   req_i    [N]        per-port request, held with data until acked
//   data_i   [N*WIDTH]  port k data at [k*WIDTH +: WIDTH]
//   ack_o    [N]        one-hot, combinational: port's data captured this cycle
//   sel_o    [SEL_W]    index of the port whose beat is in data_o
//   data_o   [WIDTH]    registered beat
//   valid_o             data_o/sel_o hold a beat
//   ready_i             downstream takes the beat when valid_o && ready_i
//   busy_o              same as valid_o
module mux8_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int N         = 8,
  parameter int BURST_LEN = 4,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [N-1:0]       ack_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(BURST_LEN);
  localparam logic [SEL_W:0]   N_W       = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N - 1);

  // IDLE: no beat held. STREAM: beat held, stage loaded last cycle.
  // HOLD: beat held across a stall. valid_o is simply state != IDLE.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] owner_q;
  logic             owner_vld_q;
  logic [BC_W-1:0]  beat_cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] data_q;

  logic             load_en;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W:0]   sum;

  assign valid_o = (state_q != ST_IDLE);
  assign busy_o  = valid_o;
  assign sel_o   = sel_q;
  assign data_o  = data_q;
  assign load_en = !valid_o || ready_i;

  // Winner: continue the current burst if allowed, else first requester
  // at or after ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    if (owner_vld_q && req_i[owner_q] && (beat_cnt_q < BURST_MAX)) begin
      win_found = 1'b1;
      win_idx   = owner_q;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        sum = {1'b0, ptr_q} + (SEL_W + 1)'(i);
        if (sum >= N_W) begin
          sum = sum - N_W;
        end
        if (!win_found && req_i[sum[SEL_W-1:0]]) begin
          win_found = 1'b1;
          win_idx   = sum[SEL_W-1:0];
        end
      end
    end
  end

  assign ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    ack_o   = '0;
    if (load_en) begin
      state_d = win_found ? ST_STREAM : ST_IDLE;
      if (win_found && !rst_i) begin
        ack_o[win_idx] = 1'b1;
      end
    end else begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      beat_cnt_q  <= '0;
      sel_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        if (win_found) begin
          data_q <= data_i[win_idx*WIDTH +: WIDTH];
          sel_q  <= win_idx;
          ptr_q  <= ptr_next;
          if (owner_vld_q && (win_idx == owner_q)) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end else begin
            owner_q     <= win_idx;
            owner_vld_q <= 1'b1;
            beat_cnt_q  <= BC_W'(1);
          end
        end else begin
          owner_vld_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
//   Drives mux8_rr_arbiter (WIDTH=8, N=8, BURST_LEN=4) one cycle per step.
//   Each step states the inputs, the expected ack_o, and whether a beat is
//   expected on the output. Expected beats are queued from the expected ack
//   and the data the bench drove, then compared when they appear.
module tb_mux8_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  req_i = '0;
  logic [63:0] data_i = '0;
  logic [7:0]  ack_o;
  logic [2:0]  sel_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  mux8_rr_arbiter #(
    .WIDTH    (8),
    .N        (8),
    .BURST_LEN(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .data_i (data_i),
    .ack_o  (ack_o),
    .sel_o  (sel_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o (busy_o)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] ack;
    logic       vld;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  vec_t  vecs[$];
  beat_t exp_q[$];
  beat_t held;
  logic [7:0] dport[8];
  logic  prev_rst = 1'b1;
  int    checks   = 0;
  int    failures = 0;
  int    step_no  = 0;

  function automatic void add(input logic r, input logic [7:0] rq, input logic rdy,
                              input logic [7:0] eack, input logic evld);
    vec_t v;
    v.rst = r; v.req = rq; v.rdy = rdy; v.ack = eack; v.vld = evld;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step_no, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic rdy,
                      input logic [7:0] eack, input logic evld);
    beat_t b;
    @(posedge clk_i);
    #1;
    rst_i   = r;
    req_i   = rq;
    ready_i = rdy;
    for (int k = 0; k < 8; k++) data_i[k*8 +: 8] = dport[k];
    @(negedge clk_i);
    step_no++;
    if (exp_q.size() != 0) held = exp_q.pop_front();
    check("valid", 8'(valid_o), 8'(evld));
    check("busy", 8'(busy_o), 8'(evld));
    if (evld) begin
      check("sel", 8'(sel_o), 8'(held.sel));
      check("data", data_o, held.data);
    end
    if (prev_rst) begin
      check("rst_sel", 8'(sel_o), 8'h00);
      check("rst_data", data_o, 8'h00);
    end
    check("ack", ack_o, eack);
    prev_rst = r;
    for (int k = 0; k < 8; k++) begin
      if (eack[k]) begin
        b.sel  = 3'(k);
        b.data = dport[k];
        exp_q.push_back(b);
        dport[k] = dport[k] + 8'h3B;
      end
    end
  endtask

  initial begin
    held.sel  = '0;
    held.data = '0;
    for (int k = 0; k < 8; k++) dport[k] = 8'(k * 17 + 7);

    // Reset with all ports requesting, then full load: 4-beat bursts rotating 0..7..0
    add(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
    for (int b = 0; b <= 32; b++)
      add(1'b0, 8'hFF, 1'b1, 8'(1 << ((b / 4) % 8)), b > 0);
    // Backpressure for 5 cycles, then grant resumes in the ready cycle
    for (int s = 0; s < 5; s++)
      add(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    add(1'b0, 8'hFF, 1'b1, 8'h01, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].ack, vecs[i].vld);

    // Short burst on port 2, port 5 continuous; port 2 returns after 4 port-5 beats
    step(1'b0, 8'h24, 1'b1, 8'h04, 1'b0);
    step(1'b0, 8'h24, 1'b1, 8'h04, 1'b1);
    step(1'b0, 8'h20, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h20, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h24, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h24, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h24, 1'b1, 8'h04, 1'b1);
    step(1'b0, 8'h20, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    // Single request on port 3, dropped after ack
    dport[3] = 8'hA5;
    step(1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    // Reset while holding a stalled beat; search restarts at index 0
    step(1'b0, 8'h01, 1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h90, 1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h90, 1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h80, 1'b1, 8'h80, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_beats step=%0d got=%0d want=0", step_no, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
